// File: rtl/fp_operand_sequencer.sv
// fp_operand_sequencer: front end of the FP adder.
// Accepts an operand pair over valid/ready, unpacks both operands, orders
// them by effective exponent and launches the Control FSM with a one-cycle
// Go pulse. The ordered operand fields stay stable until the next capture.
// Inf/NaN operands skip Control and produce a one-cycle special-result strobe.
//
// Ports:
//   Clock, ResetN         clock (rising edge), async active-low reset
//   InValid / InReady     operand-pair handshake
//   OpA, OpB              operands {sign, exp, frac}
//   Result                Control done strobe
//   Go                    one-cycle launch to Control
//   ExpSet                1: A is the big operand (Ea >= Eb), 0: B is big
//   ExpDiff, ExpBig       exponent distance and big effective exponent
//   MantBig, MantSmall    {hidden, frac} of big / small operand
//   SignBig, SignSmall    signs of big / small operand
//   SpecialValid/Code     special-result strobe, 01 +Inf, 10 -Inf, 11 NaN
//   Error                 one-cycle Result-timeout strobe
module fp_operand_sequencer #(
    parameter int unsigned EXPBITS      = 8,
    parameter int unsigned MANTISSABITS = 23,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                                Clock,
    input  logic                                ResetN,
    input  logic                                InValid,
    output logic                                InReady,
    input  logic [EXPBITS+MANTISSABITS:0]       OpA,
    input  logic [EXPBITS+MANTISSABITS:0]       OpB,
    input  logic                                Result,
    output logic                                Go,
    output logic                                ExpSet,
    output logic [EXPBITS-1:0]                  ExpDiff,
    output logic [EXPBITS-1:0]                  ExpBig,
    output logic [MANTISSABITS:0]               MantBig,
    output logic [MANTISSABITS:0]               MantSmall,
    output logic                                SignBig,
    output logic                                SignSmall,
    output logic                                SpecialValid,
    output logic [1:0]                          SpecialCode,
    output logic                                Error
);

    localparam int unsigned OPW  = 1 + EXPBITS + MANTISSABITS;
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMP     = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_SPECIAL = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [OPW-1:0]  op_a_q, op_b_q;
    logic            in_ready_d, go_d, special_valid_d, error_d;
    logic            capture_en, cmp_en;

    // Field unpack of the captured operands
    logic                    sign_a, sign_b;
    logic [EXPBITS-1:0]      exp_a, exp_b;
    logic [MANTISSABITS-1:0] frac_a, frac_b;
    logic                    hid_a, hid_b;
    logic [EXPBITS-1:0]      eff_a, eff_b;
    logic [MANTISSABITS:0]   mant_a, mant_b;
    logic                    a_big;
    logic [EXPBITS-1:0]      exp_diff;
    logic                    all1_a, all1_b, nan_a, nan_b, inf_a, inf_b;
    logic                    special_any;
    logic [1:0]              special_code;

    assign sign_a = op_a_q[OPW-1];
    assign sign_b = op_b_q[OPW-1];
    assign exp_a  = op_a_q[OPW-2 -: EXPBITS];
    assign exp_b  = op_b_q[OPW-2 -: EXPBITS];
    assign frac_a = op_a_q[MANTISSABITS-1:0];
    assign frac_b = op_b_q[MANTISSABITS-1:0];

    // Denormals carry no hidden bit and use effective exponent 1
    assign hid_a  = |exp_a;
    assign hid_b  = |exp_b;
    assign eff_a  = hid_a ? exp_a : EXPBITS'(1);
    assign eff_b  = hid_b ? exp_b : EXPBITS'(1);
    assign mant_a = {hid_a, frac_a};
    assign mant_b = {hid_b, frac_b};

    // Ties pick A as the big operand, so the difference is never negative
    assign a_big    = (eff_a >= eff_b);
    assign exp_diff = a_big ? (eff_a - eff_b) : (eff_b - eff_a);

    // Special-value classification
    assign all1_a      = &exp_a;
    assign all1_b      = &exp_b;
    assign nan_a       = all1_a & (|frac_a);
    assign nan_b       = all1_b & (|frac_b);
    assign inf_a       = all1_a & ~(|frac_a);
    assign inf_b       = all1_b & ~(|frac_b);
    assign special_any = all1_a | all1_b;

    // Any NaN or opposite-signed infinities give NaN; otherwise the Inf sign
    always_comb begin
        special_code = 2'b00;
        if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
            special_code = 2'b11;
        end else if (inf_a) begin
            special_code = sign_a ? 2'b10 : 2'b01;
        end else if (inf_b) begin
            special_code = sign_b ? 2'b10 : 2'b01;
        end
    end

    // Sequencer FSM: next state and next values of the registered controls
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        error_d    = 1'b0;
        capture_en = 1'b0;
        cmp_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (InValid && InReady) begin
                    capture_en = 1'b1;
                    state_d    = ST_CMP;
                end
            end
            ST_CMP: begin
                cmp_en  = 1'b1;
                state_d = special_any ? ST_SPECIAL : ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = Result ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (Result) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_SPECIAL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d      = (state_d == ST_IDLE);
        go_d            = (state_d == ST_ISSUE);
        special_valid_d = (state_d == ST_SPECIAL);
    end

    // State and control registers
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            InReady      <= 1'b1;
            Go           <= 1'b0;
            SpecialValid <= 1'b0;
            Error        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            InReady      <= in_ready_d;
            Go           <= go_d;
            SpecialValid <= special_valid_d;
            Error        <= error_d;
        end
    end

    // Operand capture and ordered-operand outputs
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            ExpSet      <= 1'b0;
            ExpDiff     <= '0;
            ExpBig      <= '0;
            MantBig     <= '0;
            MantSmall   <= '0;
            SignBig     <= 1'b0;
            SignSmall   <= 1'b0;
            SpecialCode <= 2'b00;
        end else begin
            if (capture_en) begin
                op_a_q <= OpA;
                op_b_q <= OpB;
            end
            if (cmp_en) begin
                ExpSet      <= a_big;
                ExpDiff     <= exp_diff;
                ExpBig      <= a_big ? eff_a : eff_b;
                MantBig     <= a_big ? mant_a : mant_b;
                MantSmall   <= a_big ? mant_b : mant_a;
                SignBig     <= a_big ? sign_a : sign_b;
                SignSmall   <= a_big ? sign_b : sign_a;
                SpecialCode <= special_any ? special_code : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_fp_operand_sequencer.sv
// Scoreboard bench for fp_operand_sequencer (single precision, TIMEOUT 64).
module tb_fp_operand_sequencer;

    localparam int unsigned EB = 8;
    localparam int unsigned MB = 23;
    localparam int unsigned TO = 64;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        InValid;
    logic        InReady;
    logic [31:0] OpA, OpB;
    logic        Result;
    logic        Go, ExpSet;
    logic [7:0]  ExpDiff, ExpBig;
    logic [23:0] MantBig, MantSmall;
    logic        SignBig, SignSmall, SpecialValid, Error;
    logic [1:0]  SpecialCode;

    fp_operand_sequencer #(.EXPBITS(EB), .MANTISSABITS(MB), .TIMEOUT(TO)) dut (
        .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .OpA(OpA), .OpB(OpB), .Result(Result), .Go(Go), .ExpSet(ExpSet),
        .ExpDiff(ExpDiff), .ExpBig(ExpBig), .MantBig(MantBig), .MantSmall(MantSmall),
        .SignBig(SignBig), .SignSmall(SignSmall), .SpecialValid(SpecialValid),
        .SpecialCode(SpecialCode), .Error(Error)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // kind: 0 Go launch, 1 special strobe, 2 timeout error
    typedef struct {
        int         kind;
        int         cyc;
        logic [66:0] fields;
        logic [1:0] code;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none (cycle %0d)", name, cyc);
    endtask

    // Reference: IEEE unpack and ordering rules with plain integer arithmetic
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int c);
        exp_t e;
        int ea, eb, effa, effb, diff;
        logic [23:0] ma, mbv;
        bit nan_a, nan_b, inf_a, inf_b;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        effa = (ea == 0) ? 1 : ea;
        effb = (eb == 0) ? 1 : eb;
        ma   = {(ea != 0), a[22:0]};
        mbv  = {(eb != 0), b[22:0]};
        e.cyc  = c;
        e.code = 2'b00;
        if (effa >= effb) begin
            diff     = effa - effb;
            e.fields = {1'b1, 8'(diff), 8'(effa), ma, mbv, a[31], b[31]};
        end else begin
            diff     = effb - effa;
            e.fields = {1'b0, 8'(diff), 8'(effb), mbv, ma, b[31], a[31]};
        end
        if (ea == 255 || eb == 255) begin
            e.kind = 1;
            nan_a = (ea == 255) && (a[22:0] != 0);
            nan_b = (eb == 255) && (b[22:0] != 0);
            inf_a = (ea == 255) && (a[22:0] == 0);
            inf_b = (eb == 255) && (b[22:0] == 0);
            if (nan_a || nan_b || (inf_a && inf_b && a[31] != b[31])) e.code = 2'b11;
            else if (inf_a) e.code = a[31] ? 2'b10 : 2'b01;
            else            e.code = b[31] ? 2'b10 : 2'b01;
        end else begin
            e.kind = 0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      e = 8'd0;
        else if (r == 1) e = 8'hFF;
        else if (r == 2) e = 8'd1;
        else             e = 8'($urandom_range(1, 254));
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // Monitor: pops the scoreboard on every DUT strobe and checks held fields
    initial begin : monitor
        bit          hold;
        bit          prev_ready;
        logic [66:0] held;
        exp_t        e;
        hold = 1'b0;
        prev_ready = 1'b1;
        held = '0;
        forever begin
            @(negedge Clock);
            if (!ResetN) hold = 1'b0;
            else if (!InReady && prev_ready) hold = 1'b0;
            prev_ready = InReady;
            if (Go) begin
                if (sbq.size() == 0) unexpected("go_unexpected");
                else begin
                    e = sbq.pop_front();
                    check("go_kind", 0, e.kind);
                    check("go_cycle", cyc, e.cyc);
                    check("go_fields", {ExpSet, ExpDiff, ExpBig, MantBig, MantSmall, SignBig, SignSmall}, e.fields);
                    hold = 1'b1;
                    held = e.fields;
                end
            end else if (hold && ResetN) begin
                check("hold_fields", {ExpSet, ExpDiff, ExpBig, MantBig, MantSmall, SignBig, SignSmall}, held);
            end
            if (SpecialValid) begin
                if (sbq.size() == 0) unexpected("special_unexpected");
                else begin
                    e = sbq.pop_front();
                    check("special_kind", 1, e.kind);
                    check("special_cycle", cyc, e.cyc);
                    check("special_code", SpecialCode, e.code);
                end
            end
            if (Error) begin
                if (sbq.size() == 0) unexpected("error_unexpected");
                else begin
                    e = sbq.pop_front();
                    check("error_kind", 2, e.kind);
                    check("error_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // mode 0: Result after random delay, 1: no Result (timeout), 2: reset mid-WAIT
    task automatic send(input logic [31:0] a, input logic [31:0] b, input int mode, input bit spurious);
        int   waited;
        int   c0;
        int   d;
        exp_t e, er;
        waited = 0;
        while (!InReady && waited < 200) begin
            @(negedge Clock);
            waited++;
        end
        if (!InReady) begin
            unexpected("ready_wait_timeout");
            return;
        end
        c0 = cyc + 1;
        OpA = a;
        OpB = b;
        InValid = 1'b1;
        e = model(a, b, c0 + 1);
        sbq.push_back(e);
        if (e.kind == 0 && mode == 1) begin
            er = e;
            er.kind = 2;
            er.cyc = c0 + 2 + int'(TO);
            sbq.push_back(er);
        end
        @(negedge Clock);
        InValid = 1'b0;
        OpA = $urandom;
        OpB = $urandom;
        Result = spurious;
        @(negedge Clock);
        Result = 1'b0;
        if (e.kind == 1) begin
            @(negedge Clock);
            check("ready_after_special", InReady, 1);
            return;
        end
        if (mode == 0) begin
            d = $urandom_range(0, 6);
            repeat (d) @(negedge Clock);
            check("busy_before_result", InReady, 0);
            Result = 1'b1;
            @(negedge Clock);
            Result = 1'b0;
            check("ready_after_result", InReady, 1);
        end else if (mode == 1) begin
            repeat (TO) @(negedge Clock);
            check("busy_before_timeout", InReady, 0);
            @(negedge Clock);
            check("ready_after_timeout", InReady, 1);
        end else begin
            repeat (3) @(negedge Clock);
            #2 ResetN = 1'b0;
            #1;
            check("rst_mid_ready", InReady, 1);
            check("rst_mid_go", Go, 0);
            check("rst_mid_expset", ExpSet, 0);
            check("rst_mid_expdiff", ExpDiff, 0);
            check("rst_mid_mantbig", MantBig, 0);
            check("rst_mid_error", Error, 0);
            @(negedge Clock);
            #2 ResetN = 1'b1;
            @(negedge Clock);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin : stimulus
        ResetN  = 1'b0;
        InValid = 1'b0;
        Result  = 1'b0;
        OpA     = '0;
        OpB     = '0;
        repeat (3) @(negedge Clock);
        check("reset_inready", InReady, 1);
        check("reset_go", Go, 0);
        check("reset_expdiff", ExpDiff, 0);
        check("reset_special_valid", SpecialValid, 0);
        check("reset_error", Error, 0);
        check("reset_special_code", SpecialCode, 0);
        ResetN = 1'b1;
        @(negedge Clock);

        send(32'h42A00000, 32'h40000000, 0, 1'b0);
        send(32'h40000000, 32'h42A00000, 0, 1'b0);
        send(32'h3F800000, 32'hBF800000, 0, 1'b1);
        send(32'h00000001, 32'h00800000, 0, 1'b0);
        send(32'h7F800000, 32'hFF800000, 0, 1'b0);
        send(32'h7F800000, 32'h3F800000, 0, 1'b1);
        send(32'h7FC00000, 32'h3F800000, 0, 1'b0);
        send(32'h42A00000, 32'h40000000, 1, 1'b0);
        send(32'h3F800000, 32'h40000000, 2, 1'b0);
        send(32'h42A00000, 32'h40000000, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            send(rand_op(), rand_op(), 0, 1'($urandom_range(0, 3) == 0));
        end
        send(rand_op() & 32'h7F7FFFFF, 32'h00000000, 1, 1'b0);
        send(rand_op(), rand_op(), 0, 1'b0);

        repeat (10) @(negedge Clock);
        check("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
